tlb_asid: RTL and testbench
===========================

TLB_ASID -- requirements
Module: tlb_asid

Interface
REQ-001 SHALL have parameter WAYS, default 4, meaning associativity; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 32, meaning number of sets; power of two, 2..64; IDX_W = log2(SETS).
REQ-003 SHALL have parameter VPN_W, default 20, meaning the VPN width (Sv32).
REQ-004 SHALL have parameter PTE_W, default 64, meaning the stored PTE width.
REQ-005 SHALL have parameter ASID_W, default 9, meaning the ASID width.
REQ-006 SHALL have parameter XLEN, default 32, meaning the flush address width.
REQ-007 SHALL have port clk  input  1  clock; the block uses one clock and all state is updated on its rising edge.
REQ-008 SHALL have port rstn  input  1  reset; reset is synchronous and active-low.
REQ-009 SHALL have port cs  input  1  access request.
REQ-010 SHALL have port we  input  1  fill (1) or lookup (0).
REQ-011 SHALL have port vpn  input  VPN_W  virtual page number.
REQ-012 SHALL have port asid  input  ASID_W  current ASID.
REQ-013 SHALL have port spage  input  1  fill is a 4 MiB superpage.
REQ-014 SHALL have port global_in  input  1  fill entry is global (PTE.G).
REQ-015 SHALL have port pte_in  input  PTE_W  fill data.
REQ-016 SHALL have port pte_hit  output  1  lookup hit, valid in the cycle after the request.
REQ-017 SHALL have port pte_out  output  PTE_W  hit data, valid with pte_hit.
REQ-018 SHALL have ports flush_req, flush_all_vaddr and flush_all_asid  input  1 each  SFENCE.VMA request and qualifiers.
REQ-019 SHALL have port flush_vaddr  input  XLEN  flush address; VPN = flush_vaddr[31:12].
REQ-020 SHALL have port flush_asid  input  XLEN  flush ASID, taken from bits [ASID_W-1:0].
REQ-021 SHALL have port busy  output  1  flush in progress.
REQ-022 SHALL have port flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-023 SHALL form idx = vpn[10+:IDX_W] and tag = {vpn[VPN_W-1:IDX_W+10], vpn[9:0]}; for superpage entries, vpn[9:0] is excluded from the compare.
REQ-024 SHALL store, per way and set: valid, spg, glb, asid, tag, pte, and an age of log2(WAYS) bits.
REQ-025 SHALL give lookups (cs & ~we & ~busy) a latency of 1: hit = valid & tag match & (glb | asid match); pte_hit registered; at most one way hits.
REQ-026 SHALL, on a superpage hit, drive pte_out = stored pte OR (latched vpn[9:0] at bits [19:10]); otherwise pte_out = stored pte; when pte_hit=0, pte_out = 0.
REQ-027 SHALL update LRU on a lookup hit of way w, in the response cycle: ages greater than age[w] decrement by 1, and age[w] becomes WAYS-1 (MRU).
REQ-028 SHALL complete a fill (cs & we & ~busy) in 1 cycle with the victim chosen as the lowest-index invalid way, else the way with age 0; the victim is written with valid=1, spg=spage, glb=global_in and the asid, tag and pte, and LRU is updated as in REQ-027.
REQ-029 SHALL produce pte_hit=0 in the cycle after a fill.
REQ-030 SHALL accept flush_req only when busy=0; a flush_req while busy=1 is ignored.
REQ-031 SHALL implement FSM IDLE -> WALK -> IDLE, with busy=1 in WALK; flush_done pulses in the cycle after the last WALK cycle.
REQ-032 SHALL walk a single set (WALK = 1 cycle) when both flush_all_vaddr and flush_all_asid are set; in that cycle every entry in all sets, global entries included, is invalidated.
REQ-033 SHALL walk a single set (WALK = 1 cycle) when flush_all_vaddr=0; the set is flush_vaddr's idx; it invalidates tag-matching entries, with spg masking as in REQ-023; if flush_all_asid=0, only entries with glb=0 and a matching asid are invalidated.
REQ-034 SHALL walk all sets (WALK = SETS cycles, set counter 0..SETS-1) when flush_all_vaddr=1 and flush_all_asid=0, invalidating entries with glb=0 and a matching asid.
REQ-035 SHALL latch the flush operands at acceptance.
REQ-036 SHALL leave ages unchanged on a flush.
REQ-037 SHALL drop a lookup or fill presented in the same cycle as an accepted flush_req, or while busy=1; no state changes and pte_hit=0 the next cycle.
REQ-038 SHALL answer a lookup followed by a fill to the same set in the next cycle with the pre-fill contents.

Reset
REQ-039 SHALL, on rstn=0 at a clock edge, clear all valid bits, set age[w]=w for every set, set the FSM to IDLE, and drive pte_hit=0, pte_out=0, busy=0 and flush_done=0.
REQ-040 SHALL, when reset is asserted during WALK, abort the walk with no flush_done pulse.

Verification
REQ-041 SHALL verify: fill vpn=0x12345, asid=3, pte=0xA5, then look up asid=3 -> pte_hit=1 and pte_out=0xA5 one cycle later; a lookup with asid=4 -> miss.
REQ-042 SHALL verify: superpage fill vpn=0x12000 with pte ppn1 set, then look up vpn=0x123FF -> hit, and pte_out[19:10] = 0x3FF.
REQ-043 SHALL verify, with WAYS=4: fill 4 tags into set 0, hit way 0, fill a 5th -> way 1 is replaced and the way-0 tag still hits.
REQ-044 SHALL verify: one global and one non-global asid=5 entry, then flush all_vaddr=1, all_asid=0, asid=5 -> busy for SETS cycles, flush_done pulses, the global entry hits and the non-global one misses.
REQ-045 SHALL verify: a lookup presented in the flush_req cycle -> pte_hit=0; a flush_req while busy is ignored, so exactly one flush_done pulse occurs.
REQ-046 SHALL verify: rstn=0 mid-walk -> busy=0, no flush_done, and every lookup misses.

Source files
------------

// File: rtl/tlb_asid.sv
// Set-associative TLB with ASID tags, 4 MiB superpages, age-based LRU and an SFENCE.VMA walker.
// Lookups answer one cycle after the request; fills take one cycle; requests are dropped while busy.
module tlb_asid #(
   parameter int WAYS   = 4,
   parameter int SETS   = 32,
   parameter int VPN_W  = 20,
   parameter int PTE_W  = 64,
   parameter int ASID_W = 9,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cs,
   input  logic              we,
   input  logic [VPN_W-1:0]  vpn,
   input  logic [ASID_W-1:0] asid,
   input  logic              spage,
   input  logic              global_in,
   input  logic [PTE_W-1:0]  pte_in,
   output logic              pte_hit,
   output logic [PTE_W-1:0]  pte_out,
   input  logic              flush_req,
   input  logic              flush_all_vaddr,
   input  logic              flush_all_asid,
   input  logic [XLEN-1:0]   flush_vaddr,
   input  logic [XLEN-1:0]   flush_asid,
   output logic              busy,
   output logic              flush_done
);
   localparam int IDX_W = $clog2(SETS);
   localparam int AGE_W = $clog2(WAYS);
   localparam int TAG_W = VPN_W - IDX_W;

   typedef enum logic {IDLE, WALK} state_t;

   logic              valid_q [SETS][WAYS];
   logic              spg_q   [SETS][WAYS];
   logic              glb_q   [SETS][WAYS];
   logic [ASID_W-1:0] asid_q  [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [PTE_W-1:0]  pte_q   [SETS][WAYS];
   logic [AGE_W-1:0]  age_q   [SETS][WAYS];

   state_t            state_q;
   logic              busy_q, flush_done_q, pte_hit_q;
   logic [PTE_W-1:0]  pte_out_q;
   logic [IDX_W-1:0]  cnt_q;
   logic              f_all_vaddr_q, f_all_asid_q;
   logic [VPN_W-1:0]  f_vpn_q;
   logic [ASID_W-1:0] f_asid_q;

   // Superpage entries ignore the 10 low VPN bits held at the bottom of the tag.
   function automatic logic tag_eq(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b,
                                   input logic spg);
      tag_eq = spg ? (a[TAG_W-1:10] == b[TAG_W-1:10]) : (a == b);
   endfunction

   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             lookup_go, fill_go;

   assign req_idx   = vpn[10 +: IDX_W];
   assign req_tag   = {vpn[VPN_W-1:IDX_W+10], vpn[9:0]};
   assign lookup_go = cs & ~we & ~busy_q & ~flush_req;
   assign fill_go   = cs &  we & ~busy_q & ~flush_req;

   logic             hit_any, hit_spg;
   logic [AGE_W-1:0] hit_way;
   logic [PTE_W-1:0] hit_pte, spg_bits;

   always_comb begin
      hit_any = 1'b0;
      hit_spg = 1'b0;
      hit_way = '0;
      hit_pte = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_eq(tag_q[req_idx][w], req_tag, spg_q[req_idx][w]) &&
             (glb_q[req_idx][w] || (asid_q[req_idx][w] == asid))) begin
            hit_any = 1'b1;
            hit_spg = spg_q[req_idx][w];
            hit_way = AGE_W'(w);
            hit_pte = pte_q[req_idx][w];
         end
      end
      spg_bits = '0;
      if (hit_spg) spg_bits[19:10] = vpn[9:0];
   end

   logic             vic_found;
   logic [AGE_W-1:0] vic_way;

   always_comb begin
      vic_found = 1'b0;
      vic_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!vic_found && !valid_q[req_idx][w]) begin
            vic_found = 1'b1;
            vic_way   = AGE_W'(w);
         end
      end
      if (!vic_found) begin
         for (int w = 0; w < WAYS; w++)
            if (age_q[req_idx][w] == '0) vic_way = AGE_W'(w);
      end
   end

   // Touched way becomes MRU; only the ways younger than it slide down.
   logic [AGE_W-1:0] touch_way, touch_age;
   logic [AGE_W-1:0] age_d [WAYS];

   always_comb begin
      touch_way = lookup_go ? hit_way : vic_way;
      touch_age = age_q[req_idx][touch_way];
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == touch_way)
            age_d[w] = AGE_W'(WAYS - 1);
         else if (age_q[req_idx][w] > touch_age)
            age_d[w] = age_q[req_idx][w] - AGE_W'(1);
         else
            age_d[w] = age_q[req_idx][w];
      end
   end

   logic [IDX_W-1:0] walk_set;
   logic [TAG_W-1:0] f_tag;
   logic             flush_every, last_walk;
   logic [WAYS-1:0]  kill;

   assign walk_set    = f_all_vaddr_q ? cnt_q : f_vpn_q[10 +: IDX_W];
   assign f_tag       = {f_vpn_q[VPN_W-1:IDX_W+10], f_vpn_q[9:0]};
   assign flush_every = f_all_vaddr_q & f_all_asid_q;
   assign last_walk   = ~(f_all_vaddr_q & ~f_all_asid_q) | (cnt_q == IDX_W'(SETS - 1));

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         kill[w] = valid_q[walk_set][w] &&
                   (f_all_vaddr_q || tag_eq(tag_q[walk_set][w], f_tag, spg_q[walk_set][w])) &&
                   (f_all_asid_q || (!glb_q[walk_set][w] && (asid_q[walk_set][w] == f_asid_q)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               age_q[s][w]   <= AGE_W'(w);
            end
         end
         pte_hit_q <= 1'b0;
         pte_out_q <= '0;
      end else begin
         pte_hit_q <= 1'b0;
         pte_out_q <= '0;
         if (busy_q) begin
            if (flush_every) begin
               for (int s = 0; s < SETS; s++)
                  for (int w = 0; w < WAYS; w++)
                     valid_q[s][w] <= 1'b0;
            end else begin
               for (int w = 0; w < WAYS; w++)
                  if (kill[w]) valid_q[walk_set][w] <= 1'b0;
            end
         end else if (lookup_go && hit_any) begin
            pte_hit_q <= 1'b1;
            pte_out_q <= hit_pte | spg_bits;
            for (int w = 0; w < WAYS; w++) age_q[req_idx][w] <= age_d[w];
         end else if (fill_go) begin
            valid_q[req_idx][vic_way] <= 1'b1;
            for (int w = 0; w < WAYS; w++) age_q[req_idx][w] <= age_d[w];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_go) begin
         spg_q[req_idx][vic_way]  <= spage;
         glb_q[req_idx][vic_way]  <= global_in;
         asid_q[req_idx][vic_way] <= asid;
         tag_q[req_idx][vic_way]  <= req_tag;
         pte_q[req_idx][vic_way]  <= pte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         flush_done_q  <= 1'b0;
         cnt_q         <= '0;
         f_all_vaddr_q <= 1'b0;
         f_all_asid_q  <= 1'b0;
         f_vpn_q       <= '0;
         f_asid_q      <= '0;
      end else begin
         flush_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_req) begin
                  state_q       <= WALK;
                  busy_q        <= 1'b1;
                  cnt_q         <= '0;
                  f_all_vaddr_q <= flush_all_vaddr;
                  f_all_asid_q  <= flush_all_asid;
                  f_vpn_q       <= flush_vaddr[12 +: VPN_W];
                  f_asid_q      <= flush_asid[ASID_W-1:0];
               end
            end
            WALK: begin
               if (last_walk) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  flush_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + IDX_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{flush_vaddr, flush_asid};

   assign pte_hit    = pte_hit_q;
   assign pte_out    = pte_out_q;
   assign busy       = busy_q;
   assign flush_done = flush_done_q;
endmodule

// File: tb/tb_tlb_asid.sv
// Directed bench for tlb_asid: lookup/fill, superpages, LRU, flush modes, drops and reset mid-walk.
module tb_tlb_asid;
   logic        clk = 1'b0;
   logic        rstn, cs, we, spage, global_in;
   logic [19:0] vpn;
   logic [8:0]  asid;
   logic [63:0] pte_in, pte_out;
   logic        pte_hit, busy, flush_done;
   logic        flush_req, flush_all_vaddr, flush_all_asid;
   logic [31:0] flush_vaddr, flush_asid;

   int checks = 0;
   int failures = 0;

   tlb_asid dut (
      .clk(clk), .rstn(rstn), .cs(cs), .we(we), .vpn(vpn), .asid(asid),
      .spage(spage), .global_in(global_in), .pte_in(pte_in),
      .pte_hit(pte_hit), .pte_out(pte_out),
      .flush_req(flush_req), .flush_all_vaddr(flush_all_vaddr), .flush_all_asid(flush_all_asid),
      .flush_vaddr(flush_vaddr), .flush_asid(flush_asid),
      .busy(busy), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   task automatic do_fill(input logic [19:0] v, input logic [8:0] a, input logic sp,
                          input logic g, input logic [63:0] p);
      cs = 1'b1; we = 1'b1; vpn = v; asid = a; spage = sp; global_in = g; pte_in = p;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; spage = 1'b0; global_in = 1'b0;
   endtask

   task automatic do_lookup(input logic [19:0] v, input logic [8:0] a,
                            output logic h, output logic [63:0] p);
      cs = 1'b1; we = 1'b0; vpn = v; asid = a;
      @(negedge clk);
      h = pte_hit; p = pte_out;
      cs = 1'b0;
   endtask

   task automatic do_flush(input logic all_v, input logic all_a, input logic [19:0] fv,
                           input logic [8:0] fa, input int samples,
                           output int busy_n, output int done_n);
      flush_req = 1'b1; flush_all_vaddr = all_v; flush_all_asid = all_a;
      flush_vaddr = {fv, 12'h000}; flush_asid = {23'd0, fa};
      @(negedge clk);
      flush_req = 1'b0;
      busy_n = 0; done_n = 0;
      for (int i = 0; i < samples; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) busy_n++;
         if (flush_done) done_n++;
      end
   endtask

   task automatic test_reset();
      logic h; logic [63:0] p;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({pte_hit, busy, flush_done} !== 3'b000 || pte_out !== 64'd0) begin
         failures++;
         $display("FAIL reset_outputs: hit/busy/done=%b pte_out=%h want 000 / 0", {pte_hit, busy, flush_done}, pte_out);
      end
      rstn = 1'b1;
      @(negedge clk);
      do_lookup(20'h00000, 9'd0, h, p);
      checks++;
      if (h !== 1'b0 || p !== 64'd0) begin
         failures++; $display("FAIL reset_lookup_miss: hit=%b pte=%h want 0/0", h, p);
      end
   endtask

   task automatic test_basic();
      logic h; logic [63:0] p;
      do_fill(20'h12345, 9'd3, 1'b0, 1'b0, 64'hA5);
      checks++;
      if (pte_hit !== 1'b0) begin failures++; $display("FAIL fill_no_hit: hit=%b want 0", pte_hit); end
      do_lookup(20'h12345, 9'd3, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'hA5) begin
         failures++; $display("FAIL basic_hit: hit=%b pte=%h want 1/a5", h, p);
      end
      do_lookup(20'h12345, 9'd4, h, p);
      checks++;
      if (h !== 1'b0 || p !== 64'd0) begin
         failures++; $display("FAIL basic_asid_miss: hit=%b pte=%h want 0/0", h, p);
      end
   endtask

   task automatic test_superpage();
      logic h; logic [63:0] p;
      do_fill(20'h12000, 9'd7, 1'b1, 1'b0, 64'h3000_00CF);
      do_lookup(20'h123FF, 9'd7, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'h300F_FCCF) begin
         failures++; $display("FAIL spage_hit: hit=%b pte=%h want 1/300ffccf", h, p);
      end
      checks++;
      if (p[19:10] !== 10'h3FF) begin
         failures++; $display("FAIL spage_low_vpn: pte[19:10]=%h want 3ff", p[19:10]);
      end
      do_lookup(20'h1A3FF, 9'd7, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL spage_upper_miss: hit=%b want 0", h); end
   endtask

   task automatic test_lru();
      logic h; logic [63:0] p;
      for (int i = 1; i <= 4; i++) do_fill(20'(i), 9'd1, 1'b0, 1'b0, 64'(32'h100 + i));
      do_lookup(20'h00001, 9'd1, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'h101) begin
         failures++; $display("FAIL lru_hit_way0: hit=%b pte=%h want 1/101", h, p);
      end
      do_fill(20'h00005, 9'd1, 1'b0, 1'b0, 64'h105);
      for (int i = 1; i <= 5; i++) begin
         do_lookup(20'(i), 9'd1, h, p);
         checks++;
         if (h !== (i != 2)) begin
            failures++; $display("FAIL lru_after_evict vpn=%0d: hit=%b want %b", i, h, (i != 2));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic h; logic [63:0] p;
      cs = 1'b1; we = 1'b0; vpn = 20'h00001; asid = 9'd1;
      @(negedge clk);
      checks++;
      if (pte_hit !== 1'b1 || pte_out !== 64'h101) begin
         failures++; $display("FAIL b2b_lookup: hit=%b pte=%h want 1/101", pte_hit, pte_out);
      end
      we = 1'b1; vpn = 20'h00006; pte_in = 64'h106;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      checks++;
      if (pte_hit !== 1'b0) begin failures++; $display("FAIL b2b_fill_nohit: hit=%b want 0", pte_hit); end
      do_lookup(20'h00006, 9'd1, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'h106) begin
         failures++; $display("FAIL b2b_new_hit: hit=%b pte=%h want 1/106", h, p);
      end
      do_lookup(20'h00003, 9'd1, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL b2b_lru_victim: hit=%b want 0", h); end
   endtask

   task automatic test_flush_asid();
      logic h; logic [63:0] p; int bn, dn;
      do_fill(20'h20400, 9'd5, 1'b0, 1'b1, 64'h5A);
      do_fill(20'h20800, 9'd5, 1'b0, 1'b0, 64'h5B);
      do_fill(20'h20C00, 9'd6, 1'b0, 1'b0, 64'h6C);
      do_flush(1'b1, 1'b0, 20'h0, 9'd5, 40, bn, dn);
      checks++;
      if (bn !== 32 || dn !== 1) begin
         failures++; $display("FAIL flush_asid_timing: busy_cycles=%0d dones=%0d want 32/1", bn, dn);
      end
      do_lookup(20'h20400, 9'd5, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'h5A) begin
         failures++; $display("FAIL flush_asid_global: hit=%b pte=%h want 1/5a", h, p);
      end
      do_lookup(20'h20800, 9'd5, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL flush_asid_nonglobal: hit=%b want 0", h); end
      do_lookup(20'h20C00, 9'd6, h, p);
      checks++;
      if (h !== 1'b1) begin failures++; $display("FAIL flush_asid_other: hit=%b want 1", h); end
   endtask

   task automatic test_flush_drop();
      logic h; logic [63:0] p; int dn;
      flush_req = 1'b1; flush_all_vaddr = 1'b0; flush_all_asid = 1'b0;
      flush_vaddr = {20'h20C00, 12'h000}; flush_asid = 32'd9;
      cs = 1'b1; we = 1'b0; vpn = 20'h12345; asid = 9'd3;
      @(negedge clk);
      checks++;
      if (pte_hit !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL drop_lookup: hit=%b busy=%b want 0/1", pte_hit, busy);
      end
      we = 1'b1; vpn = 20'h30000; pte_in = 64'h77;
      @(negedge clk);
      flush_req = 1'b0; cs = 1'b0; we = 1'b0;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (flush_done) dn++;
      end
      checks++;
      if (dn !== 1) begin failures++; $display("FAIL busy_flush_ignored: dones=%0d want 1", dn); end
      do_lookup(20'h30000, 9'd3, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL drop_fill: hit=%b want 0", h); end
      do_lookup(20'h20C00, 9'd6, h, p);
      checks++;
      if (h !== 1'b1) begin failures++; $display("FAIL drop_flush_asid9: hit=%b want 1", h); end
   endtask

   task automatic test_flush_vaddr();
      logic h; logic [63:0] p; int bn, dn;
      do_flush(1'b0, 1'b0, 20'h20C00, 9'd6, 10, bn, dn);
      checks++;
      if (bn !== 1 || dn !== 1) begin
         failures++; $display("FAIL flush_vaddr_timing: busy_cycles=%0d dones=%0d want 1/1", bn, dn);
      end
      do_lookup(20'h20C00, 9'd6, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL flush_vaddr_kill: hit=%b want 0", h); end
      do_lookup(20'h12345, 9'd3, h, p);
      checks++;
      if (h !== 1'b1 || p !== 64'hA5) begin
         failures++; $display("FAIL flush_vaddr_keep: hit=%b pte=%h want 1/a5", h, p);
      end
   endtask

   task automatic test_flush_all();
      logic h; logic [63:0] p; int bn, dn;
      do_flush(1'b1, 1'b1, 20'h0, 9'd0, 10, bn, dn);
      checks++;
      if (bn !== 1 || dn !== 1) begin
         failures++; $display("FAIL flush_all_timing: busy_cycles=%0d dones=%0d want 1/1", bn, dn);
      end
      do_lookup(20'h20400, 9'd5, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL flush_all_global: hit=%b want 0", h); end
      do_lookup(20'h00001, 9'd1, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL flush_all_set0: hit=%b want 0", h); end
   endtask

   task automatic test_reset_mid_walk();
      logic h; logic [63:0] p; int dn;
      do_fill(20'h12345, 9'd3, 1'b0, 1'b0, 64'hA5);
      do_fill(20'h20400, 9'd5, 1'b0, 1'b1, 64'h5A);
      flush_req = 1'b1; flush_all_vaddr = 1'b1; flush_all_asid = 1'b0; flush_asid = 32'd1;
      @(negedge clk);
      flush_req = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL midwalk_busy: busy=%b want 1", busy); end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || flush_done !== 1'b0) begin
         failures++; $display("FAIL midwalk_reset: busy=%b done=%b want 0/0", busy, flush_done);
      end
      rstn = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (flush_done) dn++;
      end
      checks++;
      if (dn !== 0) begin failures++; $display("FAIL midwalk_no_done: dones=%0d want 0", dn); end
      do_lookup(20'h12345, 9'd3, h, p);
      checks++;
      if (h !== 1'b0 || p !== 64'd0) begin
         failures++; $display("FAIL midwalk_miss_a: hit=%b pte=%h want 0/0", h, p);
      end
      do_lookup(20'h20400, 9'd5, h, p);
      checks++;
      if (h !== 1'b0) begin failures++; $display("FAIL midwalk_miss_g: hit=%b want 0", h); end
   endtask

   initial begin
      rstn = 1'b0; cs = 1'b0; we = 1'b0; vpn = '0; asid = '0; spage = 1'b0;
      global_in = 1'b0; pte_in = '0; flush_req = 1'b0; flush_all_vaddr = 1'b0;
      flush_all_asid = 1'b0; flush_vaddr = '0; flush_asid = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_superpage();
      test_lru();
      test_back_to_back();
      test_flush_asid();
      test_flush_drop();
      test_flush_vaddr();
      test_flush_all();
      test_reset_mid_walk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
